jetpack_game_core: RTL and testbench
====================================

// Module: jetpack_game_core
// PURPOSE
//  Single-clock core of the jetpack runner. Three parts:
//  - free-running clock divider that produces the game-tick enable;
//  - player ("barry") vertical physics plus the game state machine;
//  - per-pixel colour renderer ("animator").
//  Sits between the VGA driver (x/y in, r/g/b out) and the external obstacle generator and score counter.
// PARAMETERS
//  DIV_BIT  11   divider bit that sets the tick; period = 2^(DIV_BIT+1) clk cycles
//  STEP     8    player pixels moved per tick
//  BARRY_X0 20   player left edge; width 30, height 60
//  FLOOR_Y  420  max y0 (480-60)
// PORTS
//  clk            in  1   CLOCK_50 domain, single clock
//  reset          in  1   synchronous, active-low (0 = reset)
//  on             in  1   synchronised thrust/start button, 1 = pressed
//  x              in  10  current pixel column, 0..639
//  y              in  9   current pixel row, 0..479
//  obs1_x, obs2_x in  10  obstacle left edges
//  obs1_pos, obs2_pos   in 2  obstacle lane, 0..2
//  obs1_type, obs2_type in 2  0=none, 1=laser, 2=zapper, 3=missile
//  divided_clocks out 32  divider counter
//  tick           out 1   one-cycle game-tick enable
//  y0             out 9   player top edge
//  game_state     out 2   00=TITLE, 01=PLAY, 10=OVER
//  game_over      out 1   1 while in OVER
//  r, g, b        out 8 each  pixel colour
// BEHAVIOUR
//  Reset values: divided_clocks=0, y0=FLOOR_Y, game_state=TITLE, game_over=0, rgb=0, tick=0.
//  Divider:
//  - divided_clocks += 1 every clk, wraps at 2^32.
//  - tick = 1 when divided_clocks[DIV_BIT:0] == {1'b0, all ones}.
//  Start/restart on an `on` rising edge (previous `on` registered; the edge register resets to 0):
//  - TITLE -> PLAY: next clk, no tick needed. y0 = FLOOR_Y on entry.
//  - OVER  -> TITLE: next clk.
//  Physics (PLAY, on tick only):
//  - on=1: y0 -= STEP, saturating at 0.
//  - on=0: y0 += STEP, saturating at FLOOR_Y.
//  - TITLE and OVER: y0 frozen.
//  Obstacle geometry:
//  - box x in [obsN_x, obsN_x+19];
//  - y in [pos*160, pos*160+159];
//  - type 0 = absent; pos 3 is treated as lane 2.
//  Collision: on a tick in PLAY, if the player box [20..49]x[y0..y0+59] overlaps any present obstacle box
//  (inclusive bounds, 11-bit compare), go to OVER the same clk.
//  Simultaneous collision and `on` edge: collision wins.
//  Renderer:
//  - rgb is registered, 1-cycle latency from x/y.
//  - Priority: player > obstacle1 > obstacle2 > background.
//  - Player FF8000 in all states.
//  - Laser FF0000, zapper FFFF00, missile FFFFFF.
//  - Background: TITLE 000080, PLAY 202020, OVER 800000.
//  - Pixels with x>639 or y>479 render 000000.
// CONFIGURATION
//  JETPACK_GOD_MODE_EN
//  - defined: collision detection is disabled; the game never enters OVER.
//  - undefined: behaviour as above.
// STRUCTURE
//  Package jetpack_pkg holds:
//  - state enum TITLE/PLAY/OVER;
//  - 24-bit colour constants;
//  - geometry constants (screen 640x480, player 30x60, obstacle 20x160, lane pitch 160).
//  One sub-module, jetpack_clk_div: the 32-bit counter plus tick.
//  Physics, FSM and renderer stay in the top.
// TESTING (bench uses DIV_BIT=0, so tick every 2 clks)
//  1. Hold reset=0 for 5 clks, then check x=0,y=0 -> divided_clocks=0, y0=420, state 00, rgb next clk 000080.
//  2. `on` high 5 clks then low, while in TITLE -> state 01 one clk after the first edge; y0 stays 420 until ticks begin.
//  3. In PLAY, hold on=1 for 10 ticks -> y0=340; hold 60 ticks -> y0 saturates at 0, never wraps.
//  4. Release on -> y0 increases 8 per tick, saturates at 420.
//  5. obs1_type=1, pos=0, obs1_x=25, y0=100 -> next tick state 10, game_over=1.
//     With JETPACK_GOD_MODE_EN defined, state stays 01.
//  6. Pixel (30,y0+10) -> FF8000; pixel on obs1 outside the player -> FF0000; pixel (700,10) -> 000000.

Source files
------------

// File: rtl/jetpack_pkg.sv
// Shared types, colours and screen geometry for the jetpack runner core.
package jetpack_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        OVER  = 2'b10
    } game_state_t;

    localparam logic [23:0] COL_PLAYER   = 24'hFF8000;
    localparam logic [23:0] COL_LASER    = 24'hFF0000;
    localparam logic [23:0] COL_ZAPPER   = 24'hFFFF00;
    localparam logic [23:0] COL_MISSILE  = 24'hFFFFFF;
    localparam logic [23:0] COL_BG_TITLE = 24'h000080;
    localparam logic [23:0] COL_BG_PLAY  = 24'h202020;
    localparam logic [23:0] COL_BG_OVER  = 24'h800000;
    localparam logic [23:0] COL_BLACK    = 24'h000000;

    localparam logic [10:0] SCREEN_W   = 11'd640;
    localparam logic [10:0] SCREEN_H   = 11'd480;
    localparam logic [10:0] PLAYER_W   = 11'd30;
    localparam logic [10:0] PLAYER_H   = 11'd60;
    localparam logic [10:0] OBS_W      = 11'd20;
    localparam logic [10:0] OBS_H      = 11'd160;
    localparam logic [10:0] LANE_PITCH = 11'd160;

    // Lane 3 is not a real lane and folds onto the bottom one.
    function automatic logic [10:0] lane_top(input logic [1:0] pos);
        case (pos)
            2'd0:    return 11'd0;
            2'd1:    return LANE_PITCH;
            default: return LANE_PITCH + LANE_PITCH;
        endcase
    endfunction

    function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] len);
        return (v >= lo) && (v <= lo + len - 11'd1);
    endfunction

    function automatic logic spans_overlap(input logic [10:0] a_lo, input logic [10:0] a_len,
                                           input logic [10:0] b_lo, input logic [10:0] b_len);
        return (a_lo <= b_lo + b_len - 11'd1) && (b_lo <= a_lo + a_len - 11'd1);
    endfunction

    function automatic logic [23:0] obs_colour(input logic [1:0] kind);
        case (kind)
            2'd1:    return COL_LASER;
            2'd2:    return COL_ZAPPER;
            2'd3:    return COL_MISSILE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/jetpack_game_core_clk_div.sv
// Free-running 32-bit divider; tick pulses for one clk each time the low
// DIV_BIT+1 counter bits equal 0 followed by all ones.
module jetpack_clk_div #(
    parameter int DIV_BIT = 11
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] divided_clocks,
    output logic        tick
);

    localparam logic [31:0] MATCH_FULL = (32'd1 << DIV_BIT) - 32'd1;

    logic [31:0] next_count;
    assign next_count = divided_clocks + 32'd1;

    // Tick is registered from the next count so it lines up with the counter value it decodes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            divided_clocks <= 32'd0;
            tick           <= 1'b0;
        end else begin
            divided_clocks <= next_count;
            tick           <= (next_count[DIV_BIT:0] == MATCH_FULL[DIV_BIT:0]);
        end
    end

endmodule

// File: rtl/jetpack_game_core.sv
// Jetpack runner core: tick divider, player physics, game FSM and pixel renderer.
// Define JETPACK_GOD_MODE_EN to disable collision detection (the game never reaches OVER).
module jetpack_game_core
    import jetpack_pkg::*;
#(
    parameter int DIV_BIT  = 11,
    parameter int STEP     = 8,
    parameter int BARRY_X0 = 20,
    parameter int FLOOR_Y  = 420
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        on,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [9:0]  obs1_x,
    input  logic [9:0]  obs2_x,
    input  logic [1:0]  obs1_pos,
    input  logic [1:0]  obs2_pos,
    input  logic [1:0]  obs1_type,
    input  logic [1:0]  obs2_type,
    output logic [31:0] divided_clocks,
    output logic        tick,
    output logic [8:0]  y0,
    output logic [1:0]  game_state,
    output logic        game_over,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam logic [8:0]  STEP_W  = 9'(STEP);
    localparam logic [8:0]  FLOOR_W = 9'(FLOOR_Y);
    localparam logic [10:0] BARRY_W = 11'(BARRY_X0);

    game_state_t state_r, state_next;
    logic        on_prev_r;
    logic        rise_s;
    logic [8:0]  y0_next;
    logic [10:0] y0_w, x_w, y_w;
    logic        obs1_hit_s, obs2_hit_s, collide_s;
    logic        on_player_s, on_obs1_s, on_obs2_s;
    logic [23:0] bg_s, pix_s;

    jetpack_clk_div #(.DIV_BIT(DIV_BIT)) u_clk_div (
        .clk            (clk),
        .reset          (reset),
        .divided_clocks (divided_clocks),
        .tick           (tick)
    );

    assign rise_s     = on & ~on_prev_r;
    assign y0_w       = {2'b00, y0};
    assign x_w        = {1'b0, x};
    assign y_w        = {2'b00, y};
    assign game_state = state_r;

    assign obs1_hit_s = (obs1_type != 2'd0)
                      && spans_overlap(BARRY_W, PLAYER_W, {1'b0, obs1_x}, OBS_W)
                      && spans_overlap(y0_w, PLAYER_H, lane_top(obs1_pos), OBS_H);
    assign obs2_hit_s = (obs2_type != 2'd0)
                      && spans_overlap(BARRY_W, PLAYER_W, {1'b0, obs2_x}, OBS_W)
                      && spans_overlap(y0_w, PLAYER_H, lane_top(obs2_pos), OBS_H);
`ifdef JETPACK_GOD_MODE_EN
    assign collide_s = 1'b0;
`else
    assign collide_s = obs1_hit_s | obs2_hit_s;
`endif

    // Game FSM next state; a collision tick in PLAY outranks any button edge.
    always_comb begin
        state_next = state_r;
        case (state_r)
            TITLE: begin
                if (rise_s) state_next = PLAY;
                else        state_next = TITLE;
            end
            PLAY: begin
                if (tick && collide_s) state_next = OVER;
                else                   state_next = PLAY;
            end
            OVER: begin
                if (rise_s) state_next = TITLE;
                else        state_next = OVER;
            end
            default: state_next = TITLE;
        endcase
    end

    // Vertical physics: saturating move per tick while playing, parked on the floor at start.
    always_comb begin
        y0_next = y0;
        if (state_r == TITLE && state_next == PLAY) begin
            y0_next = FLOOR_W;
        end else if (state_r == PLAY && state_next == PLAY && tick) begin
            if (on) y0_next = (y0 < STEP_W) ? 9'd0 : (y0 - STEP_W);
            else    y0_next = (y0 > FLOOR_W - STEP_W) ? FLOOR_W : (y0 + STEP_W);
        end else begin
            y0_next = y0;
        end
    end

    // FSM, button history and player position registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= TITLE;
            on_prev_r <= 1'b0;
            y0        <= FLOOR_W;
            game_over <= 1'b0;
        end else begin
            state_r   <= state_next;
            on_prev_r <= on;
            y0        <= y0_next;
            game_over <= (state_next == OVER);
        end
    end

    assign on_player_s = in_span(x_w, BARRY_W, PLAYER_W) && in_span(y_w, y0_w, PLAYER_H);
    assign on_obs1_s   = (obs1_type != 2'd0) && in_span(x_w, {1'b0, obs1_x}, OBS_W)
                       && in_span(y_w, lane_top(obs1_pos), OBS_H);
    assign on_obs2_s   = (obs2_type != 2'd0) && in_span(x_w, {1'b0, obs2_x}, OBS_W)
                       && in_span(y_w, lane_top(obs2_pos), OBS_H);

    // Pixel colour selection by layer priority.
    always_comb begin
        case (state_r)
            TITLE:   bg_s = COL_BG_TITLE;
            PLAY:    bg_s = COL_BG_PLAY;
            OVER:    bg_s = COL_BG_OVER;
            default: bg_s = COL_BLACK;
        endcase
        if (x_w > SCREEN_W - 11'd1 || y_w > SCREEN_H - 11'd1) pix_s = COL_BLACK;
        else if (on_player_s)                                 pix_s = COL_PLAYER;
        else if (on_obs1_s)                                   pix_s = obs_colour(obs1_type);
        else if (on_obs2_s)                                   pix_s = obs_colour(obs2_type);
        else                                                  pix_s = bg_s;
    end

    // Registered colour output, one clk behind x/y.
    always_ff @(posedge clk) begin
        if (!reset) begin
            {r, g, b} <= 24'h000000;
        end else begin
            {r, g, b} <= pix_s;
        end
    end

endmodule

// File: tb/tb_jetpack_game_core.sv
// Scoreboard bench for jetpack_game_core with DIV_BIT=0 (tick every 2 clks).
module tb_jetpack_game_core;

    logic        clk = 1'b0;
    logic        reset, on;
    logic [9:0]  x, obs1_x, obs2_x;
    logic [8:0]  y;
    logic [1:0]  obs1_pos, obs2_pos, obs1_type, obs2_type;
    logic [31:0] divided_clocks;
    logic        tick, game_over;
    logic [8:0]  y0;
    logic [1:0]  game_state;
    logic [7:0]  r, g, b;

    jetpack_game_core #(.DIV_BIT(0)) dut (
        .clk(clk), .reset(reset), .on(on), .x(x), .y(y),
        .obs1_x(obs1_x), .obs2_x(obs2_x), .obs1_pos(obs1_pos), .obs2_pos(obs2_pos),
        .obs1_type(obs1_type), .obs2_type(obs2_type),
        .divided_clocks(divided_clocks), .tick(tick), .y0(y0),
        .game_state(game_state), .game_over(game_over), .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   rel_cyc = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return divided_clocks;
            1:       return {31'd0, tick};
            2:       return {23'd0, y0};
            3:       return {30'd0, game_state};
            4:       return {31'd0, game_over};
            5:       return {8'd0, r, g, b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops every expectation that has come due and compares it.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (actual(mon_e.sel) !== mon_e.exp) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", mon_e.name, actual(mon_e.sel), mon_e.exp);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [31:0] exp, input int lat);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int   seen = 0;
        int   guard = 0;
        logic t;
        while (seen < n && guard < 4 * n + 16) begin
            @(negedge clk);
            t = tick;
            @(posedge clk);
            #1;
            if (t) seen++;
            guard++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL tick_wait: got %0d ticks expected %0d", seen, n);
        end
    endtask

    task automatic pix(input string name, input int px, input int py, input logic [31:0] exp);
        x = 10'(px);
        y = 9'(py);
        push(name, 5, exp, 1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bg;
        int          py;
        reset = 1'b0; on = 1'b0; x = 10'd0; y = 9'd0;
        obs1_x = 10'd0; obs2_x = 10'd0; obs1_pos = 2'd0; obs2_pos = 2'd0;
        obs1_type = 2'd0; obs2_type = 2'd0;
        step(5);
        push("rst_div", 0, 32'd0, 0);
        push("rst_tick", 1, 32'd0, 0);
        push("rst_y0", 2, 32'd420, 0);
        push("rst_state", 3, 32'd0, 0);
        push("rst_over", 4, 32'd0, 0);
        push("rst_rgb", 5, 32'h000000, 0);

        reset = 1'b1;
        step(1);
        rel_cyc = cyc;
        push("rgb_title", 5, 32'h000080, 0);
        push("div_first", 0, 32'd1, 0);
        push("tick_first", 1, 32'd0, 0);

        on = 1'b1;
        step(1);
        push("start_state", 3, 32'd1, 0);
        push("start_y0", 2, 32'd420, 0);
        wait_ticks(10); push("climb10", 2, 32'd340, 0);
        wait_ticks(42); push("climb52", 2, 32'd4, 0);
        wait_ticks(8);  push("ceiling", 2, 32'd0, 0);

        on = 1'b0;
        wait_ticks(1);  push("fall1", 2, 32'd8, 0);
        wait_ticks(51); push("fall52", 2, 32'd416, 0);
        wait_ticks(1);  push("floor", 2, 32'd420, 0);
        wait_ticks(3);  push("floor_hold", 2, 32'd420, 0);

        // Obstacles just left and right of the player: no collision while climbing.
        obs1_x = 10'd50; obs1_type = 2'd1; obs1_pos = 2'd0;
        obs2_x = 10'd0;  obs2_type = 2'd3; obs2_pos = 2'd0;
        on = 1'b1;
        wait_ticks(40);
        push("near_miss_state", 3, 32'd1, 0);
        push("near_miss_y0", 2, 32'd100, 0);

        obs1_x = 10'd25;
        obs2_x = 10'd300; obs2_type = 2'd2; obs2_pos = 2'd3;
        on = 1'b0;
        wait_ticks(1);
`ifdef JETPACK_GOD_MODE_EN
        push("hit_state", 3, 32'd1, 0);
        push("hit_y0", 2, 32'd108, 0);
        wait_ticks(60);
        push("god_floor", 2, 32'd420, 0);
        bg = 32'h202020;
        py = 430;
`else
        push("hit_state", 3, 32'd2, 0);
        push("hit_over", 4, 32'd1, 0);
        push("hit_y0", 2, 32'd100, 0);
        bg = 32'h800000;
        py = 110;
`endif
        pix("pix_player", 30, py, 32'hFF8000);
        pix("pix_laser", 30, 50, 32'hFF0000);
        pix("pix_laser_edge", 44, 50, 32'hFF0000);
        pix("pix_laser_past", 45, 50, bg);
        pix("pix_zapper_lane3", 305, 400, 32'hFFFF00);
        pix("pix_zapper_xpast", 320, 400, bg);
        pix("pix_zapper_yabove", 305, 319, bg);
        pix("pix_offscreen_x", 700, 10, 32'h000000);
        pix("pix_offscreen_y", 100, 480, 32'h000000);
        obs1_type = 2'd3;
        pix("pix_missile", 30, 50, 32'hFFFFFF);
        obs2_x = 10'd25; obs2_pos = 2'd0;
        pix("pix_priority", 30, 50, 32'hFFFFFF);
        obs1_type = 2'd0;
        pix("pix_obs2_only", 30, 50, 32'hFFFF00);

        on = 1'b1;
        step(1);
`ifdef JETPACK_GOD_MODE_EN
        push("restart_state", 3, 32'd1, 0);
        pix("pix_restart_bg", 300, 300, 32'h202020);
`else
        push("restart_state", 3, 32'd0, 0);
        push("restart_over", 4, 32'd0, 0);
        pix("pix_restart_bg", 300, 300, 32'h000080);
`endif
        push("div_count", 0, 32'(cyc - rel_cyc + 1), 0);

        step(3);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
